// File: rtl/stream_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_debug_pkg
// Brief    : Shared constants for the stream debug monitor: control-word bit
//            positions, readout field codes, status2 marker and legal
//            parameter ranges.
// Revision : 1.0 - initial release
// ============================================================================
package stream_debug_pkg;

  // Bit positions inside the host control word
  localparam int CTRL_SNAP_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_CH_LSB   = 4;
  localparam int CTRL_CH_MSB   = 7;
  localparam int CTRL_FLD_LSB  = 8;
  localparam int CTRL_FLD_MSB  = 9;

  // Readout field codes
  typedef enum logic [1:0] {
    FLD_BEAT   = 2'd0,
    FLD_PKT    = 2'd1,
    FLD_STALL  = 2'd2,
    FLD_STATUS = 2'd3
  } field_e;

  // Top byte of status2: bit 31 set marks a live monitor, rest reserved
  localparam logic [7:0] STATUS2_MARKER = 8'h80;

  // Per-channel counter indices
  localparam int NUM_CNT   = 3;
  localparam int CNT_BEAT  = 0;
  localparam int CNT_PKT   = 1;
  localparam int CNT_STALL = 2;

  // Legal parameter ranges
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 16;
  localparam int CNT_WIDTH_MIN   = 8;
  localparam int CNT_WIDTH_MAX   = 32;
  localparam int LED_DIV_BIT_MIN = 3;
  localparam int LED_DIV_BIT_MAX = 31;

endpackage
`default_nettype wire

// File: rtl/stream_debug_chan_cnt.sv
`default_nettype none
// ============================================================================
// Module   : stream_debug_chan_cnt
// Brief    : One monitored channel: live beat/packet/stall counters with
//            saturate-or-wrap behaviour, sticky overflow flag, and shadow
//            copies loaded on snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module stream_debug_chan_cnt
  import stream_debug_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tvalid,
  input  logic                 tready,
  input  logic                 tlast,
  input  logic                 snap,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] shadow_beat,
  output logic [CNT_WIDTH-1:0] shadow_pkt,
  output logic [CNT_WIDTH-1:0] shadow_stall,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_CNT-1:0]   inc;
  logic [NUM_CNT-1:0]   hit;
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];

  assign inc[CNT_BEAT]  = tvalid & tready;
  assign inc[CNT_PKT]   = tvalid & tready & tlast;
  assign inc[CNT_STALL] = tvalid & ~tready;

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] live;
    logic [CNT_WIDTH-1:0] live_nxt;
    logic [CNT_WIDTH-1:0] shadow_q;
    logic                 at_max;

    // Next live value: hold, step, or at all-ones either stick or roll over
    always_comb begin
      at_max   = &live;
      live_nxt = live;
      if (inc[k]) begin
        if (at_max) begin
          live_nxt = (SATURATE != 0) ? live : '0;
        end else begin
          live_nxt = live + c_one;
        end
      end
    end

    assign hit[k] = inc[k] & at_max;

    // Live counter register; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
      if (rst) begin
        live <= '0;
      end else if (clr) begin
        live <= '0;
      end else begin
        live <= live_nxt;
      end
    end

    // Shadow captures the registered value, so a same-cycle beat is excluded
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
      end else if (snap) begin
        shadow_q <= live;
      end
    end

    assign shadow[k] = shadow_q;
  end

  // Sticky overflow: any counter of this channel stepping past all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (|hit) begin
      ovf <= 1'b1;
    end
  end

  assign shadow_beat  = shadow[CNT_BEAT];
  assign shadow_pkt   = shadow[CNT_PKT];
  assign shadow_stall = shadow[CNT_STALL];

endmodule
`default_nettype wire

// File: rtl/stream_debug_monitor.sv
`default_nettype none
// ============================================================================
// Module   : stream_debug_monitor
// Brief    : Per-channel AXI-Stream beat/packet/stall monitor with host
//            snapshot/clear via the GPIO output word, selectable readout on
//            the GPIO input words and a heartbeat/error LED pattern.
// Revision : 1.0 - initial release
// ============================================================================
module stream_debug_monitor
  import stream_debug_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_WIDTH   = 32,
  parameter int SATURATE    = 1,
  parameter int LED_DIV_BIT = 23
) (
  input  logic              c0_ddr4_clk,
  input  logic              c0_ddr4_rst,
  input  logic [NUM_CH-1:0] mon_tvalid,
  input  logic [NUM_CH-1:0] mon_tready,
  input  logic [NUM_CH-1:0] mon_tlast,
  input  logic              err_in,
  input  logic [7:0]        latest_buf,
  input  logic [31:0]       ctrl_in,
  output logic [31:0]       status_out,
  output logic [31:0]       status2_out,
  output logic [3:0]        user_led
);

  localparam logic [7:0] c_num_ch    = 8'(NUM_CH);
  localparam logic [7:0] c_cnt_width = 8'(CNT_WIDTH);

  // Registered copy of the control fields that matter
  logic       snap_r;
  logic       clr_r;
  logic [3:0] ch_sel_r;
  field_e     fld_sel_r;

  logic        snap_pulse;
  logic        clr_pulse;
  logic [7:0]  snap_seq;
  logic        err_sticky;
  logic [31:0] hb;
  logic [31:0] status_nxt;

  // Shadow values padded to the full 16-channel select range; unused
  // channels read as zero so an out-of-range select needs no extra check
  logic [31:0] sh_beat  [16];
  logic [31:0] sh_pkt   [16];
  logic [31:0] sh_stall [16];
  logic [15:0] ovf_all;

  assign snap_pulse = ctrl_in[CTRL_SNAP_BIT] & ~snap_r;
  assign clr_pulse  = ctrl_in[CTRL_CLR_BIT]  & ~clr_r;

  // Control word register: edge-detect history and readout selects
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      snap_r    <= 1'b0;
      clr_r     <= 1'b0;
      ch_sel_r  <= 4'd0;
      fld_sel_r <= FLD_BEAT;
    end else begin
      snap_r    <= ctrl_in[CTRL_SNAP_BIT];
      clr_r     <= ctrl_in[CTRL_CLR_BIT];
      ch_sel_r  <= ctrl_in[CTRL_CH_MSB:CTRL_CH_LSB];
      fld_sel_r <= field_e'(ctrl_in[CTRL_FLD_MSB:CTRL_FLD_LSB]);
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_chan
    if (i < NUM_CH) begin : g_live
      logic [CNT_WIDTH-1:0] s_beat;
      logic [CNT_WIDTH-1:0] s_pkt;
      logic [CNT_WIDTH-1:0] s_stall;
      logic                 ch_ovf;

      stream_debug_chan_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .SATURATE  (SATURATE)
      ) u_chan (
        .clk          (c0_ddr4_clk),
        .rst          (c0_ddr4_rst),
        .tvalid       (mon_tvalid[i]),
        .tready       (mon_tready[i]),
        .tlast        (mon_tlast[i]),
        .snap         (snap_pulse),
        .clr          (clr_pulse),
        .shadow_beat  (s_beat),
        .shadow_pkt   (s_pkt),
        .shadow_stall (s_stall),
        .ovf          (ch_ovf)
      );

      assign sh_beat[i]  = 32'(s_beat);
      assign sh_pkt[i]   = 32'(s_pkt);
      assign sh_stall[i] = 32'(s_stall);
      assign ovf_all[i]  = ch_ovf;
    end else begin : g_absent
      assign sh_beat[i]  = 32'h0;
      assign sh_pkt[i]   = 32'h0;
      assign sh_stall[i] = 32'h0;
      assign ovf_all[i]  = 1'b0;
    end
  end

  // Snapshot sequence number, wraps at 8 bits; clear leaves it alone
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      snap_seq <= 8'd0;
    end else if (snap_pulse) begin
      snap_seq <= snap_seq + 8'd1;
    end
  end

  // Sticky core error; clear overrides a same-cycle error
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      err_sticky <= 1'b0;
    end else if (clr_pulse) begin
      err_sticky <= 1'b0;
    end else if (err_in) begin
      err_sticky <= 1'b1;
    end
  end

  // Readout mux driven from registered selects
  always_comb begin
    status_nxt = 32'h0;
    case (fld_sel_r)
      FLD_BEAT:   status_nxt = sh_beat[ch_sel_r];
      FLD_PKT:    status_nxt = sh_pkt[ch_sel_r];
      FLD_STALL:  status_nxt = sh_stall[ch_sel_r];
      FLD_STATUS: status_nxt = {err_sticky, 7'b0, ovf_all, latest_buf};
      default:    status_nxt = 32'h0;
    endcase
  end

  // Registered readout keeps inputs off any combinational output path
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      status_out <= 32'h0;
    end else begin
      status_out <= status_nxt;
    end
  end

  assign status2_out = {STATUS2_MARKER, snap_seq, c_num_ch, c_cnt_width};

  // Free-running heartbeat counter
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      hb <= 32'h0;
    end else begin
      hb <= hb + 32'd1;
    end
  end

  // Walking pattern when healthy, all four LEDs blinking together on error
  always_comb begin
    user_led = hb[LED_DIV_BIT -: 4];
    if (err_sticky) begin
      user_led = {4{hb[LED_DIV_BIT]}};
    end
  end

  // Control bits with no function and heartbeat bits outside the LED tap
  logic unused_sink;
  assign unused_sink = ^{ctrl_in[31:10], ctrl_in[3:2], hb};

endmodule
`default_nettype wire

// File: tb/tb_stream_debug_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_debug_monitor
// Brief    : Self-checking bench: default-width instance plus two 8-bit
//            instances (saturating and wrapping) sharing one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_debug_monitor;

  localparam int NCH = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  tvalid;
  logic [NCH-1:0]  tready;
  logic [NCH-1:0]  tlast;
  logic            err_in;
  logic [7:0]      latest_buf;
  logic [31:0]     ctrl;

  logic [31:0] st_a, st2_a, st_s, st2_s, st_w, st2_w;
  logic [3:0]  led_a, led_s, led_w;

  logic [31:0] hb_m;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  ch;
    logic [1:0]  fld;
    logic [31:0] exp;
  } vec_t;
  vec_t vec [13];

  always #5 clk = ~clk;

  // Expected heartbeat count
  always @(posedge clk) begin
    if (rst) hb_m <= 32'h0;
    else     hb_m <= hb_m + 32'd1;
  end

  stream_debug_monitor #(.NUM_CH(NCH), .CNT_WIDTH(32), .SATURATE(1), .LED_DIV_BIT(23)) dut_a (
    .c0_ddr4_clk(clk), .c0_ddr4_rst(rst), .mon_tvalid(tvalid), .mon_tready(tready),
    .mon_tlast(tlast), .err_in(err_in), .latest_buf(latest_buf), .ctrl_in(ctrl),
    .status_out(st_a), .status2_out(st2_a), .user_led(led_a));

  stream_debug_monitor #(.NUM_CH(NCH), .CNT_WIDTH(8), .SATURATE(1), .LED_DIV_BIT(4)) dut_s (
    .c0_ddr4_clk(clk), .c0_ddr4_rst(rst), .mon_tvalid(tvalid), .mon_tready(tready),
    .mon_tlast(tlast), .err_in(err_in), .latest_buf(latest_buf), .ctrl_in(ctrl),
    .status_out(st_s), .status2_out(st2_s), .user_led(led_s));

  stream_debug_monitor #(.NUM_CH(NCH), .CNT_WIDTH(8), .SATURATE(0), .LED_DIV_BIT(4)) dut_w (
    .c0_ddr4_clk(clk), .c0_ddr4_rst(rst), .mon_tvalid(tvalid), .mon_tready(tready),
    .mon_tlast(tlast), .err_in(err_in), .latest_buf(latest_buf), .ctrl_in(ctrl),
    .status_out(st_w), .status2_out(st2_w), .user_led(led_w));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    ctrl = v;
    tick(1);
  endtask

  // Select a field; status_out follows two edges later
  task automatic read_sel(input logic [3:0] ch, input logic [1:0] fld);
    ctrl = {22'b0, fld, ch, 4'b0};
    tick(2);
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] r, input logic [2:0] l);
    tvalid = v;
    tready = r;
    tlast  = l;
    tick(1);
  endtask

  task automatic idle();
    tvalid = '0;
    tready = '0;
    tlast  = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " st_a"},  st_a,  32'h0);
    check({tag, " st2_a"}, st2_a, 32'h8000_0320);
    check({tag, " led_a"}, {28'b0, led_a}, 32'h0);
    check({tag, " st_s"},  st_s,  32'h0);
    check({tag, " st2_s"}, st2_s, 32'h8000_0308);
    check({tag, " led_s"}, {28'b0, led_s}, 32'h0);
  endtask

  initial begin
    vec[0]  = '{4'd0, 2'd0, 32'd10};
    vec[1]  = '{4'd0, 2'd1, 32'd2};
    vec[2]  = '{4'd0, 2'd2, 32'd3};
    vec[3]  = '{4'd1, 2'd0, 32'd4};
    vec[4]  = '{4'd1, 2'd1, 32'd4};
    vec[5]  = '{4'd1, 2'd2, 32'd0};
    vec[6]  = '{4'd2, 2'd0, 32'd0};
    vec[7]  = '{4'd2, 2'd2, 32'd1};
    vec[8]  = '{4'd5, 2'd0, 32'd0};
    vec[9]  = '{4'd5, 2'd1, 32'd0};
    vec[10] = '{4'd5, 2'd2, 32'd0};
    vec[11] = '{4'd5, 2'd3, 32'h0000_00A5};
    vec[12] = '{4'd3, 2'd0, 32'd0};

    rst = 1'b1;
    idle();
    err_in     = 1'b0;
    latest_buf = 8'hA5;
    ctrl       = 32'h0;
    tick(2);
    check_reset_state("reset");
    rst = 1'b0;

    // Channel 0: 10 beats, last on 5th and 10th, 3 stalls.
    // Channel 1: 4 single-beat packets. Channel 2: one stall.
    for (int i = 0; i < 4; i++) drive(3'b011, 3'b011, 3'b010);
    drive(3'b001, 3'b010, 3'b000);
    drive(3'b001, 3'b001, 3'b001);
    drive(3'b101, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) drive(3'b001, 3'b001, 3'b000);
    drive(3'b001, 3'b000, 3'b000);
    drive(3'b001, 3'b001, 3'b001);
    idle();
    tick(1);
    set_ctrl(32'h1);

    for (int i = 0; i < 13; i++) begin
      read_sel(vec[i].ch, vec[i].fld);
      check($sformatf("vec%0d ch%0d f%0d", i, vec[i].ch, vec[i].fld), st_a, vec[i].exp);
    end
    check("snap_seq after 1 snapshot", st2_a, 32'h8001_0320);

    // Single-cycle error: sticky flag and LED blink
    err_in = 1'b1;
    tick(1);
    err_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("err led c%0d", i), {28'b0, led_s}, {28'b0, {4{hb_m[4]}}});
      tick(1);
    end
    read_sel(4'd0, 2'd3);
    check("field3 err set", st_a, 32'h8000_00A5);
    set_ctrl(32'h302);
    set_ctrl(32'h300);
    check("field3 after clear", st_a, 32'h0000_00A5);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("hb led c%0d", i), {28'b0, led_s}, {28'b0, hb_m[4:1]});
      tick(1);
    end

    // 300 beats on channel 0 into 8-bit saturating and wrapping counters
    for (int i = 0; i < 300; i++) drive(3'b001, 3'b001, 3'b000);
    idle();
    set_ctrl(32'h301);
    read_sel(4'd0, 2'd0);
    check("300 beats w32", st_a, 32'd300);
    check("300 beats sat8", st_s, 32'd255);
    check("300 beats wrap8", st_w, 32'd44);
    read_sel(4'd0, 2'd3);
    check("ovf w32", st_a, 32'h0000_00A5);
    check("ovf sat8", st_s, 32'h0000_01A5);
    check("ovf wrap8", st_w, 32'h0000_01A5);
    check("snap_seq sat8", st2_s, 32'h8002_0308);

    // Reset in the middle of traffic, error and a snapshot edge
    tvalid = 3'b111;
    tready = 3'b111;
    tlast  = 3'b111;
    err_in = 1'b1;
    set_ctrl(32'h301);
    tick(1);
    rst = 1'b1;
    tick(1);
    check_reset_state("midreset");
    rst    = 1'b0;
    idle();
    err_in = 1'b0;
    read_sel(4'd0, 2'd0);
    check("midreset shadow", st_a, 32'h0);
    read_sel(4'd0, 2'd3);
    check("midreset f3 w32", st_a, 32'h0000_00A5);
    check("midreset f3 sat8", st_s, 32'h0000_00A5);

    // Snapshot and clear rising together after 7 beats
    for (int i = 0; i < 7; i++) drive(3'b001, 3'b001, 3'b000);
    idle();
    set_ctrl(32'h3);
    read_sel(4'd0, 2'd0);
    check("snap+clr shadow", st_a, 32'd7);
    set_ctrl(32'h1);
    read_sel(4'd0, 2'd0);
    check("post-clear snapshot", st_a, 32'd0);
    check("snap_seq 2", st2_a, 32'h8002_0320);

    // Beat in the clear cycle is dropped; the following beat counts
    for (int i = 0; i < 3; i++) drive(3'b001, 3'b001, 3'b000);
    ctrl = 32'h2;
    drive(3'b001, 3'b001, 3'b000);
    ctrl = 32'h0;
    drive(3'b001, 3'b001, 3'b000);
    idle();
    set_ctrl(32'h1);
    read_sel(4'd0, 2'd0);
    check("beat during clear", st_a, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_debug_monitor.md
# stream_debug_monitor

Parametrised debug/status monitor for the SDDT fabric, the successor to the single handshake counter and fixed GPIO debug packing. It observes NUM_CH AXI-Stream channels in the `c0_ddr4_clk` domain and counts beats, packets and stall cycles per channel. It takes host-triggered snapshots and clears through the GPIO output word, and returns a selectable counter or status field on the GPIO input words. It also drives a heartbeat/error indication on `user_led`.

## Interface
- NUM_CH, 3: monitored stream channels, 1..16.
- CNT_WIDTH, 32: per-counter width, 8..32; values are zero-extended to 32 bits on readout.
- SATURATE, 1: 1 makes counters hold at all-ones; 0 makes them wrap.
- LED_DIV_BIT, 23: MSB of the heartbeat tap, ≥3.
- c0_ddr4_clk  in  1  sole clock.
- c0_ddr4_rst  in  1  synchronous, active-high reset.
- mon_tvalid  in  NUM_CH  per-channel tvalid (observe only).
- mon_tready  in  NUM_CH  per-channel tready.
- mon_tlast  in  NUM_CH  per-channel tlast; tie to 1 for channels without tlast.
- err_in  in  1  core error level.
- latest_buf  in  8  core latest-buffer index.
- ctrl_in  in  32  GPIO output word: [0] snapshot, [1] clear, [7:4] channel select, [9:8] field select, other bits ignored.
- status_out  out  32  selected field.
- status2_out  out  32  identification/status word.
- user_led  out  4  heartbeat or error blink.

## Operation
- Beat on channel i = tvalid&tready; packet = beat&tlast; stall = tvalid&~tready.
- Each channel has live counters beat_cnt, pkt_cnt, stall_cnt, each CNT_WIDTH wide, plus a sticky ovf flag.
- ovf sets when any counter of that channel would pass all-ones.
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter wraps to 0.
- err_sticky sets on err_in=1 and clears only on clear or reset.
- ctrl_in is registered once into ctrl_r. snap_pulse = ctrl_in[0]&~ctrl_r[0]; clr_pulse = ctrl_in[1]&~ctrl_r[1]. Level-held bits give a single action.
- On snap_pulse, every shadow counter is loaded from its live counter's current register value, which excludes the beat in the same cycle. snap_seq (8 bit, wrapping) increments.
- On clr_pulse, live counters, ovf and err_sticky go to 0 at the next edge. A clear overrides any increment in the same cycle. Shadows and snap_seq are untouched.
- On simultaneous snap_pulse and clr_pulse, the shadow captures the pre-clear values.
- Field select:
  - 0: beat.
  - 1: pkt.
  - 2: stall, all taken from the shadow of the selected channel.
  - 3: {err_sticky, 7'b0, ovf[15:0] zero-padded beyond NUM_CH, latest_buf}, live values.
- A channel select ≥ NUM_CH returns 32'h0 for fields 0–2. Field 3 ignores channel select.
- status2_out = {1'b1, 7'b0, snap_seq, NUM_CH[7:0], CNT_WIDTH[7:0]}.
- A free-running 32-bit heartbeat counter drives user_led:
  - err_sticky=0: hb[LED_DIV_BIT:LED_DIV_BIT-3].
  - err_sticky=1: {4{hb[LED_DIV_BIT]}}.

## Timing
- Reset values: every counter, shadow, ovf, err_sticky, snap_seq, hb and ctrl_r are 0. status_out=0. status2_out={1'b1,7'b0,8'h00,NUM_CH,CNT_WIDTH}. user_led=0.
- Counter update: a beat in cycle t appears in the live counter after edge t+1.
- Snapshot: ctrl_in[0] rises and is sampled at edge t. The shadow loads at edge t+1. status_out shows the new value after edge t+2.
- Select change: status_out is registered and follows ctrl_in[9:4] two edges after the change.
- Clear: ctrl_in[1] rises at edge t. Live counters read 0 after edge t+1. Field 3 reflects the clear after edge t+2.
- Reset mid-operation: all state returns to reset values at the next edge, and any pending edge is lost.
- No combinational path from any input to any output.

## Structure
- Package stream_debug_pkg holds:
  - ctrl bit indices;
  - field codes (FLD_BEAT=0, FLD_PKT=1, FLD_STALL=2, FLD_STATUS=3);
  - the status2 marker bit;
  - the parameter range limits.
- Sub-module stream_debug_chan_cnt holds one channel's three counters, ovf, shadows and the saturate/wrap logic. It is instantiated NUM_CH times via generate.
- The top level holds the ctrl edge detect, snap_seq, err_sticky, the readout mux and the LED logic.

## Test plan
- Default params. Channel 0: 10 beats, last on the 5th and 10th, 3 stall cycles. Toggle snapshot. Expected readout: sel ch0 field0=10, field1=2, field2=3.
- CNT_WIDTH=8, SATURATE=1. 300 beats then snapshot. Expected readout: field0=255 and field3 ovf bit0=1. With SATURATE=0 the same stimulus gives field0=44 with ovf=1.
- Snapshot and clear rise in the same cycle after 7 beats. Expected: shadow=7, live=0. A later snapshot with no traffic reads 0, and snap_seq=2.
- Beat asserted in the clear cycle: expected live count 0 after the clear.
- err_in pulsed for 1 cycle. Expected: field3[31]=1 and user_led all equal to hb[LED_DIV_BIT]. After a clear, field3[31]=0.
- NUM_CH=3 with channel select 5. Expected: status_out=0 for fields 0–2. Reset asserted mid-traffic gives all reset values.
